// File: rtl/regfile_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_pkg : shared constants and address-width helper for regfile_sb
// Rev 1.0
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int MAX_PEND_DEF = 3;
  localparam int PCW          = 3;

  // Smallest w with 2**w >= depth
  function automatic int calc_aw(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_sb_if : read/issue/write bus of the scoreboarded register file
// Rev 1.0
// ----------------------------------------------------------------------------
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);

  localparam int AW = calc_aw(DEPTH);

  logic [AW-1:0]    readreg1;
  logic [AW-1:0]    readreg2;
  logic [WIDTH-1:0] readdata1;
  logic [WIDTH-1:0] readdata2;
  logic             readbusy1;
  logic             readbusy2;
  logic             issue_valid;
  logic [AW-1:0]    issue_reg;
  logic             issue_ready;
  logic             writeenable;
  logic [AW-1:0]    writereg;
  logic [WIDTH-1:0] writedata;
  logic             err_underflow;

  modport master (
    output readreg1, readreg2, issue_valid, issue_reg,
           writeenable, writereg, writedata,
    input  readdata1, readdata2, readbusy1, readbusy2,
           issue_ready, err_underflow
  );

  modport slave (
    input  readreg1, readreg2, issue_valid, issue_reg,
           writeenable, writereg, writedata,
    output readdata1, readdata2, readbusy1, readbusy2,
           issue_ready, err_underflow
  );

endinterface
`default_nettype wire

// File: rtl/regfile_pend_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_pend_ctr : saturating up/down pending-write counter for one register
// Rev 1.0
// ----------------------------------------------------------------------------
module regfile_pend_ctr
  import regfile_pkg::*;
#(
  parameter int CW = PCW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic [CW-1:0] max,
  output logic [CW-1:0] cnt,
  output logic          at_max,
  output logic          underflow
);

  logic [CW-1:0] r_cnt;

  assign cnt       = r_cnt;
  assign at_max    = (r_cnt == max);
  assign underflow = dec && (r_cnt == '0);

  // Simultaneous inc and dec cancel; dec at zero and inc at max both hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && !dec && !at_max) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (dec && !inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_sb : 2R1W register file with write bypass and pending-write scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam int            AW         = calc_aw(DEPTH);
  localparam logic [PCW-1:0] C_MAX_PEND = PCW'(MAX_PEND);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_err;
  logic [PCW-1:0]   w_cnt [DEPTH];
  logic [DEPTH-1:0] w_inc;
  logic [DEPTH-1:0] w_dec;
  logic [DEPTH-1:0] w_at_max;
  logic [DEPTH-1:0] w_uflow;
  logic [DEPTH-1:0] w_busy;
  logic             w_wr_ok;
  logic             w_iss_ok;

  function automatic logic masked(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign w_wr_ok = bus.writeenable && !masked(bus.writereg);

  // A write to the same register frees the slot the issue is about to take.
  assign bus.issue_ready = masked(bus.issue_reg) || !w_at_max[bus.issue_reg] ||
                           (bus.writeenable && (bus.writereg == bus.issue_reg));
  assign w_iss_ok = bus.issue_valid && bus.issue_ready && !masked(bus.issue_reg);

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      assign w_inc[i] = w_iss_ok && (bus.issue_reg == AW'(i));
      assign w_dec[i] = w_wr_ok  && (bus.writereg  == AW'(i));

      regfile_pend_ctr #(.CW(PCW)) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_inc[i]),
        .dec       (w_dec[i]),
        .max       (C_MAX_PEND),
        .cnt       (w_cnt[i]),
        .at_max    (w_at_max[i]),
        .underflow (w_uflow[i])
      );

      // Busy reflects the count after this cycle's issue/write are applied.
      assign w_busy[i] = (w_inc[i] && !w_dec[i]) ||
                         (w_cnt[i] > PCW'(1)) ||
                         ((w_cnt[i] == PCW'(1)) && !(w_dec[i] && !w_inc[i]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.writereg] <= bus.writedata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (|w_uflow) begin
      r_err <= 1'b1;
    end
  end

  assign bus.readdata1 = masked(bus.readreg1) ? '0 :
                         (w_wr_ok && (bus.writereg == bus.readreg1)) ? bus.writedata :
                         r_mem[bus.readreg1];
  assign bus.readdata2 = masked(bus.readreg2) ? '0 :
                         (w_wr_ok && (bus.writereg == bus.readreg2)) ? bus.writedata :
                         r_mem[bus.readreg2];

  assign bus.readbusy1     = w_busy[bus.readreg1];
  assign bus.readbusy2     = w_busy[bus.readreg2];
  assign bus.err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_sb : scoreboard bench for regfile_sb against an array/count model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int MAXP  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  regfile_sb #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .MAX_PEND (MAXP),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_mem[DEPTH];
  int          m_cnt[DEPTH];
  bit          m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("readdata1",     bus.readdata1,            e.rd1);
      chk("readdata2",     bus.readdata2,            e.rd2);
      chk("readbusy1",     32'(bus.readbusy1),       32'(e.b1));
      chk("readbusy2",     32'(bus.readbusy2),       32'(e.b2));
      chk("issue_ready",   32'(bus.issue_ready),     32'(e.rdy));
      chk("err_underflow", 32'(bus.err_underflow),   32'(e.err));
    end
  end

  function automatic logic [31:0] rd_model(input int a, input bit we, input int wr,
                                           input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wr == a) return wd;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 32'h0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endtask

  // Called at posedge+1: drive one cycle, queue its expectation, advance model.
  task automatic step(input int rr1, input int rr2, input bit iv, input int ir,
                      input bit we, input int wr, input logic [31:0] wd);
    exp_t e;
    int   nc[DEPTH];
    bit   rdy, acc, wok, uf;
    bus.readreg1    = AW'(rr1);
    bus.readreg2    = AW'(rr2);
    bus.issue_valid = iv;
    bus.issue_reg   = AW'(ir);
    bus.writeenable = we;
    bus.writereg    = AW'(wr);
    bus.writedata   = wd;
    wok = we && (wr != 0);
    rdy = (ir == 0) || (m_cnt[ir] < MAXP) || (we && wr == ir);
    acc = iv && rdy && (ir != 0);
    uf  = wok && (m_cnt[wr] == 0);
    nc  = m_cnt;
    if (!(wok && acc && wr == ir)) begin
      if (acc) nc[ir] = nc[ir] + 1;
      if (wok && m_cnt[wr] > 0) nc[wr] = nc[wr] - 1;
    end
    e.rd1 = rd_model(rr1, we, wr, wd);
    e.rd2 = rd_model(rr2, we, wr, wd);
    e.b1  = (nc[rr1] != 0);
    e.b2  = (nc[rr2] != 0);
    e.rdy = rdy;
    e.err = m_err;
    q.push_back(e);
    @(posedge clk);
    if (wok) m_mem[wr] = wd;
    m_cnt = nc;
    m_err = m_err | uf;
    #1;
  endtask

  // Pulls rst_n low between edges; the monitor checks before any rising edge.
  task automatic do_reset();
    exp_t e;
    bus.issue_valid = 1'b0;
    bus.writeenable = 1'b0;
    bus.readreg1    = AW'($urandom_range(0, DEPTH - 1));
    bus.readreg2    = AW'($urandom_range(0, DEPTH - 1));
    rst_n = 1'b0;
    model_reset();
    e.rd1 = 32'h0; e.rd2 = 32'h0;
    e.b1  = 1'b0;  e.b2  = 1'b0;
    e.rdy = 1'b1;  e.err = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.readreg1 = '0; bus.readreg2 = '0; bus.issue_valid = 1'b0; bus.issue_reg = '0;
    bus.writeenable = 1'b0; bus.writereg = '0; bus.writedata = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 16; i++) step(i, i + 16, 0, 0, 0, 0, 32'h0);

    // Bypass on reg 5 (reserved first so no underflow)
    step(5, 1, 1, 5, 0, 0, 32'h0);
    step(5, 1, 0, 0, 1, 5, 32'hDEADBEEF);
    step(5, 1, 0, 0, 0, 0, 32'h0);

    // Register 0 stays zero and never busy
    step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    step(0, 0, 1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);

    // Pending saturation on reg 7
    for (int i = 0; i < 4; i++) step(7, 7, 1, 7, 0, 0, 32'h0);
    step(7, 7, 1, 7, 1, 7, 32'hA5A5_0007);
    for (int i = 0; i < 3; i++) step(7, 7, 0, 0, 1, 7, $urandom);
    step(7, 7, 0, 0, 0, 0, 32'h0);

    // Underflow on reg 9 is sticky
    step(9, 9, 0, 0, 1, 9, 32'h12345678);
    step(9, 1, 0, 0, 0, 0, 32'h0);
    step(9, 1, 1, 3, 0, 0, 32'h0);
    step(3, 4, 1, 4, 0, 0, 32'h0);

    // Mid-operation reset with pending counts outstanding
    do_reset();
    step(3, 4, 0, 0, 0, 0, 32'h0);

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        do_reset();
      end else begin
        step($urandom_range(0, 7), ($urandom % 8 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
             ($urandom % 10) < 6, $urandom_range(0, 7),
             ($urandom % 10) < 4, $urandom_range(0, 7), $urandom);
      end
    end

    bus.issue_valid = 1'b0;
    bus.writeenable = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
